greenmachine_mode_input: RTL and testbench

Avalon-MM slave input PIO that brings the operator mode switches and buttons into the GreenMachine SoC. It is the read-side counterpart of the mode-control output PIO. It synchronises and debounces each input bit, captures edges into a sticky register, and raises a maskable interrupt to the HPS.

---
 rtl/greenmachine_pio_pkg.sv | 22 ++
 rtl/greenmachine_debounce.sv | 41 ++++
 rtl/greenmachine_mode_input.sv | 76 +++++++
 tb/tb_greenmachine_mode_input.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/greenmachine_pio_pkg.sv
// Shared definitions for the GreenMachine PIO blocks: register addresses,
// edge-type selectors and the per-bit edge qualifier.
package greenmachine_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_hit(input logic deb, input logic deb_d,
                                    input int edge_type);
    case (edge_type)
      EDGE_RISING:  return deb & ~deb_d;
      EDGE_FALLING: return ~deb & deb_d;
      default:      return deb ^ deb_d;
    endcase
  endfunction

endpackage

// File: rtl/greenmachine_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module greenmachine_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Any sample agreeing with deb clears the count, so a bounce restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      cnt   <= '0;
      deb   <= RESET_LEVEL;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/greenmachine_mode_input.sv
// Avalon-MM input PIO for the operator mode switches: debounced DATA,
// sticky EDGECAP (W1C), IRQMASK and a level interrupt to the HPS.
module greenmachine_mode_input
  import greenmachine_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = EDGE_ANY,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] w1c;
  logic             wr;
  logic             unused_bus;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    greenmachine_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .deb    (deb[i])
    );
    assign hit[i] = edge_hit(deb[i], deb_d[i], EDGE_TYPE);
  end

  assign wr  = chipselect && !write_n;
  assign w1c = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // A new edge is OR-ed in after the clear, so it wins a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d   <= {WIDTH{RESET_LEVEL}};
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      deb_d <= deb;
      if (wr && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~w1c) | hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata = 32'(deb);
      PIO_ADDR_IRQMASK: readdata = 32'(irqmask);
      PIO_ADDR_EDGECAP: readdata = 32'(edgecap);
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

  // Reads have no side effects and upper write bits have no home.
  assign unused_bus = ^{read_n, writedata};

endmodule

// File: tb/tb_greenmachine_mode_input.sv
// Scoreboarded bench: a window-based reference model predicts every read of
// the main instance; a second instance covers falling-only capture and reset level 1.
module tb_greenmachine_mode_input;
  import greenmachine_pio_pkg::*;

  localparam int W = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: any edge, reset level 0
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '0;
  logic        irq;

  // second instance: falling edges only, reset level 1
  logic        reset_n2 = 1'b0;
  logic [1:0]  address2 = '0;
  logic        cs2 = 1'b0;
  logic        write_n2 = 1'b1;
  logic        read_n2 = 1'b1;
  logic [31:0] writedata2 = '0;
  logic [31:0] readdata2;
  logic [W-1:0] in_port2 = 4'hF;
  logic        irq2;

  greenmachine_mode_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_ANY),
                            .RESET_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));

  greenmachine_mode_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_FALLING),
                            .RESET_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n2), .address(address2), .chipselect(cs2),
    .write_n(write_n2), .read_n(read_n2), .writedata(writedata2), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: a bit's debounced value follows the input once the
  // D samples taken D+1..2 edges ago all agree and differ from it.
  logic [W-1:0] m_deb = '0, m_cap = '0, m_mask = '0, m_pend = '0;
  logic [W-1:0] hist[$];

  task automatic model_step();
    logic [W-1:0] w1c;
    logic [W-1:0] nd;
    bit           same;
    if (!reset_n) begin
      hist.delete();
      m_deb = '0; m_cap = '0; m_mask = '0; m_pend = '0;
    end else begin
      w1c = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~w1c) | m_pend;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_back(in_port);
      if (hist.size() > D + 2) void'(hist.pop_front());
      nd = m_deb;
      if (hist.size() == D + 2) begin
        for (int b = 0; b < W; b++) begin
          same = 1'b1;
          for (int j = 1; j < D; j++) if (hist[j][b] != hist[0][b]) same = 1'b0;
          if (same && hist[0][b] != m_deb[b]) nd[b] = hist[0][b];
        end
      end
      m_pend = nd ^ m_deb;
      m_deb  = nd;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  // Monitor: pops an expectation whenever a DUT is presenting a read.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (chipselect && !read_n) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_sb_underflow: got read with empty queue, required queued expectation");
      end else begin
        e = q1.pop_front();
        chk($sformatf("dut1_rd_a%0d", e.a), readdata, e.data);
        chk("dut1_irq", {31'b0, irq}, {31'b0, e.irq});
      end
    end
    if (cs2 && !read_n2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_sb_underflow: got read with empty queue, required queued expectation");
      end else begin
        e = q2.pop_front();
        chk($sformatf("dut2_rd_a%0d", e.a), readdata2, e.data);
        chk("dut2_irq", {31'b0, irq2}, {31'b0, e.irq});
      end
    end
  end

  task automatic cyc1(input logic [W-1:0] pin, input bit wr, input logic [1:0] a,
                      input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    in_port = pin; address = a; chipselect = 1'b1; writedata = wd;
    if (wr) begin
      write_n = 1'b0; read_n = 1'b1;
    end else begin
      write_n = 1'b1; read_n = 1'b0;
      e.a = a;
      e.irq = |(m_cap & m_mask);
      case (a)
        2'd0:    e.data = 32'(m_deb);
        2'd2:    e.data = 32'(m_mask);
        2'd3:    e.data = 32'(m_cap);
        default: e.data = 32'h0;
      endcase
      q1.push_back(e);
    end
  endtask

  task automatic rd2(input logic [W-1:0] pin, input logic [1:0] a,
                     input logic [31:0] exp, input logic exp_irq);
    exp_t e;
    @(negedge clk);
    in_port2 = pin; address2 = a; cs2 = 1'b1; read_n2 = 1'b0; write_n2 = 1'b1;
    e.a = a; e.data = exp; e.irq = exp_irq;
    q2.push_back(e);
  endtask

  task automatic wr2(input logic [W-1:0] pin, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    in_port2 = pin; address2 = a; writedata2 = wd; cs2 = 1'b1; read_n2 = 1'b1; write_n2 = 1'b0;
  endtask

  task automatic idle2(input logic [W-1:0] pin, input int n);
    repeat (n) begin
      @(negedge clk);
      in_port2 = pin; cs2 = 1'b0; read_n2 = 1'b1; write_n2 = 1'b0 | 1'b1;
    end
  endtask

  logic [W-1:0] lvl;
  int           r;

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    reset_n2 = 1'b1;

    // reset state
    for (int a = 0; a < 4; a++) cyc1(4'h0, 1'b0, 2'(a), 32'h0);

    // clean rise on bit 0, read DATA every cycle to pin the latency
    cyc1(4'h0, 1'b1, 2'd2, 32'h1);
    for (int i = 0; i < 13; i++) cyc1(4'h1, 1'b0, (i < 11) ? 2'd0 : 2'd3, 32'h0);

    // bounce on bit 1 never gets through
    cyc1(4'h1, 1'b1, 2'd2, 32'h3);
    for (int i = 0; i < 40; i++)
      cyc1({2'b00, 1'((i / 5) % 2), 1'b1}, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
    for (int i = 0; i < 12; i++) cyc1(4'h1, 1'b0, 2'(i % 4), 32'h0);

    // W1C racing a new bit-2 capture
    cyc1(4'h1, 1'b1, 2'd3, 32'hF);
    cyc1(4'h1, 1'b1, 2'd2, 32'h4);
    for (int i = 0; i < 12; i++) cyc1(4'h5, 1'b0, 2'd3, 32'h0);
    cyc1(4'h1, 1'b0, 2'd3, 32'h0);
    for (int i = 0; i < 9; i++) cyc1(4'h1, 1'b0, 2'd3, 32'h0);
    cyc1(4'h1, 1'b1, 2'd3, 32'h4);
    cyc1(4'h1, 1'b0, 2'd3, 32'h0);
    cyc1(4'h1, 1'b1, 2'd3, 32'h4);
    cyc1(4'h1, 1'b0, 2'd3, 32'h0);

    // randomized traffic
    lvl = 4'h1;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(0, 11) == 0) lvl[b] = ~lvl[b];
      r = int'($urandom_range(0, 9));
      if (r == 0)      cyc1(lvl, 1'b1, 2'd2, $urandom);
      else if (r == 1) cyc1(lvl, 1'b1, 2'd3, $urandom);
      else if (r == 2) cyc1(lvl, 1'b1, 2'($urandom_range(0, 1)), $urandom);
      else             cyc1(lvl, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
    end
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;

    // second instance: reset level 1, falling-only capture
    rd2(4'hF, 2'd0, 32'hF, 1'b0);
    rd2(4'hF, 2'd3, 32'h0, 1'b0);
    rd2(4'h7, 2'd3, 32'h0, 1'b0);
    idle2(4'h7, 11);
    rd2(4'h7, 2'd3, 32'h8, 1'b0);
    rd2(4'h7, 2'd0, 32'h7, 1'b0);
    wr2(4'h7, 2'd2, 32'h8);
    rd2(4'h7, 2'd3, 32'h8, 1'b1);
    wr2(4'h7, 2'd3, 32'h8);
    rd2(4'h7, 2'd3, 32'h0, 1'b0);
    rd2(4'hF, 2'd0, 32'h7, 1'b0);
    idle2(4'hF, 11);
    rd2(4'hF, 2'd3, 32'h0, 1'b0);
    rd2(4'hF, 2'd0, 32'hF, 1'b0);
    rd2(4'h7, 2'd0, 32'hF, 1'b0);
    idle2(4'h7, 11);
    rd2(4'h7, 2'd3, 32'h8, 1'b1);

    // async reset while bits 0..2 are mid-count
    idle2(4'h0, 1);
    address2 = 2'd0;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_data", readdata2, 32'h7);
    chk("pre_rst_irq", {31'b0, irq2}, 32'h1);
    reset_n2 = 1'b0;
    #1;
    chk("rst_data_async", readdata2, 32'hF);
    chk("rst_irq_async", {31'b0, irq2}, 32'h0);
    @(negedge clk);
    reset_n2 = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    chk("restart_hold", readdata2, 32'hF);
    @(posedge clk);
    #2;
    chk("restart_done", readdata2, 32'h0);
    idle2(4'h0, 2);
    rd2(4'h0, 2'd3, 32'hF, 1'b0);
    rd2(4'h0, 2'd2, 32'h0, 1'b0);
    idle2(4'h0, 3);

    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
